sync_ram_clr: RTL and testbench

SYNC_RAM_CLR -- requirements
Module: sync_ram_clr

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_clear_fsm.sv | 72 +++++++
 rtl/sync_ram_clr.sv | 99 +++++++++
 tb/tb_sync_ram_clr.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types for the clearable synchronous RAM.
//   state_t : sweep controller state (IDLE, CLEAR)
// ---------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : ram_pkg

// File: rtl/ram_clear_fsm.sv
// ---------------------------------------------------------------------------
// ram_clear_fsm
// Sweep controller: walks clr_addr from 0 to DEPTH-1, one word per cycle,
// while asserting clr_we. Entered on reset or on clear while idle.
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset, restarts the sweep at 0
//   clear    : request a new sweep (ignored while a sweep runs)
//   busy     : high while the sweep runs
//   clr_we   : write strobe for the sweep
//   clr_addr : address being cleared this cycle
// ---------------------------------------------------------------------------
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // DEPTH <= 2**ADDR_W, so the last index always fits in ADDR_W bits and
    // the counter stops on it instead of wrapping.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = clr_addr;
        case (state)
            CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = IDLE;
                end else begin
                    addr_nxt = clr_addr + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    addr_nxt  = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                addr_nxt  = '0;
            end
        endcase
    end

    assign busy   = (state == CLEAR);
    assign clr_we = busy;

endmodule : ram_clear_fsm

// File: rtl/sync_ram_clr.sv
// ---------------------------------------------------------------------------
// sync_ram_clr
// Single-clock RAM with one write port, one registered read port and a
// hardware clear sweep that fills every word with INIT_VAL.
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   we,w_addr,w_data: write port (out-of-range addresses dropped)
//   re,r_addr       : read request (out-of-range returns INIT_VAL)
//   r_data, r_valid : read data, valid pulses one cycle after an accepted re
//   clear           : start a clear sweep when idle
//   busy            : sweep in progress; we/re ignored while high
// ---------------------------------------------------------------------------
module sync_ram_clr
    import ram_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 15,
    parameter int                 DEPTH    = 2**ADDR_W,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    input  logic              clear,
    output logic              busy
);

    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              accept;
    logic              w_in_range;
    logic              r_in_range;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;

    ram_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_fsm (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Port traffic is only honoured when idle and no sweep is being requested.
    assign accept     = ~busy & ~clear & ~reset;
    assign w_in_range = ({1'b0, w_addr} < DEPTH_EXT);
    assign r_in_range = ({1'b0, r_addr} < DEPTH_EXT);
    assign wr_en      = accept & we & w_in_range;
    assign rd_en      = accept & re;

    // Write-first: a same-cycle write to the read address bypasses the array.
    always_comb begin
        rd_word = INIT_VAL;
        if (wr_en && (w_addr == r_addr)) begin
            rd_word = w_data;
        end else if (r_in_range) begin
            rd_word = mem[r_addr];
        end
    end

    // ---- array write: sweep owns the port while busy ----
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (wr_en) begin
            mem[w_addr] <= w_data;
        end
    end

    // ---- read register: r_data holds between reads ----
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_en;
            if (rd_en) begin
                r_data <= rd_word;
            end
        end
    end

endmodule : sync_ram_clr

// File: tb/tb_sync_ram_clr.sv
// ---------------------------------------------------------------------------
// tb_sync_ram_clr
// Self-checking bench for sync_ram_clr (DATA_W=8, ADDR_W=4, DEPTH=12,
// INIT_VAL=8'hA5). A reference model tracks the array and sweep state;
// expected read data is queued when a read is accepted and popped when
// r_valid is seen.
// ---------------------------------------------------------------------------
module tb_sync_ram_clr;

    localparam int              DATA_W   = 8;
    localparam int              ADDR_W   = 4;
    localparam int              DEPTH    = 12;
    localparam logic [7:0]      INIT_VAL = 8'hA5;

    logic              clock;
    logic              reset;
    logic              we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              re;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              clear;
    logic              busy;

    sync_ram_clr #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .we      (we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .re      (re),
        .r_addr  (r_addr),
        .r_data  (r_data),
        .r_valid (r_valid),
        .clear   (clear),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb_q[$];

    logic [7:0] mdl_mem [DEPTH];
    bit         mdl_busy  = 1'b0;
    int         mdl_cnt   = 0;
    logic [7:0] mdl_rdata = 8'h00;
    bit         mdl_rvld  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances with the same inputs and
    // all outputs are checked 1 time unit after the rising edge.
    task automatic step(input bit rs, input bit clr,
                        input bit w, input logic [3:0] wa, input logic [7:0] wd,
                        input bit r, input logic [3:0] ra);
        logic [7:0] exp_rd;
        @(negedge clock);
        reset  = rs;
        clear  = clr;
        we     = w;
        w_addr = wa;
        w_data = wd;
        re     = r;
        r_addr = ra;

        mdl_rvld = 1'b0;
        if (rs) begin
            mdl_busy  = 1'b1;
            mdl_cnt   = 0;
            mdl_rdata = 8'h00;
            sb_q.delete();
        end else if (mdl_busy) begin
            mdl_mem[mdl_cnt] = INIT_VAL;
            if (mdl_cnt == DEPTH - 1) mdl_busy = 1'b0;
            mdl_cnt++;
        end else if (clr) begin
            mdl_busy = 1'b1;
            mdl_cnt  = 0;
        end else begin
            if (r) begin
                if (w && wa == ra && int'(wa) < DEPTH) exp_rd = wd;
                else if (int'(ra) < DEPTH)             exp_rd = mdl_mem[ra];
                else                                   exp_rd = INIT_VAL;
                sb_q.push_back(exp_rd);
                mdl_rvld  = 1'b1;
                mdl_rdata = exp_rd;
            end
            if (w && int'(wa) < DEPTH) mdl_mem[wa] = wd;
        end

        @(posedge clock);
        #1;
        check_val("busy", 32'(busy), 32'(mdl_busy));
        check_val("r_valid", 32'(r_valid), 32'(mdl_rvld));
        check_val("r_data_hold", 32'(r_data), 32'(mdl_rdata));
        if (r_valid) begin
            check_val("sb_pending", sb_q.size(), 1);
            if (sb_q.size() > 0) check_val("sb_rdata", 32'(r_data), 32'(sb_q.pop_front()));
        end else if (sb_q.size() > 0) begin
            check_val("sb_lost", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, a);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, a, d, 1'b0, 4'd0);
    endtask

    initial begin
        reset  = 1'b1;
        clear  = 1'b0;
        we     = 1'b0;
        w_addr = '0;
        w_data = '0;
        re     = 1'b0;
        r_addr = '0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;

        // Reset, full sweep, then read every word back.
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        repeat (DEPTH) idle_step();
        for (int i = 0; i < DEPTH; i++) rd(4'(i));
        idle_step();

        // Basic write/read, out-of-range write and read.
        wr(4'd5, 8'h3C);
        rd(4'd5);
        wr(4'd13, 8'hFF);
        rd(4'd13);
        rd(4'd5);
        rd(4'd15);
        idle_step();

        // Same-cycle write/read: same address, different address, out of range.
        step(1'b0, 1'b0, 1'b1, 4'd7, 8'h11, 1'b1, 4'd7);
        step(1'b0, 1'b0, 1'b1, 4'd2, 8'h22, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b1, 4'd13, 8'h33, 1'b1, 4'd13);
        rd(4'd2);
        rd(4'd7);

        // Fill array, clear with traffic on the request cycle and during busy.
        for (int i = 0; i < DEPTH; i++) wr(4'(i), 8'(i * 17 + 1));
        rd(4'd0);
        rd(4'd11);
        step(1'b0, 1'b1, 1'b1, 4'd4, 8'h44, 1'b1, 4'd4);
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, i[0], 1'b1, 4'(i), 8'h5A, 1'b1, 4'(i));
        for (int i = 0; i < DEPTH; i++) rd(4'(i));

        // Reset mid-sweep restarts it; clear during the sweep has no effect.
        for (int i = 0; i < DEPTH; i++) wr(4'(i), 8'(8'hC0 + i));
        step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        repeat (6) idle_step();
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, (i == 3 || i == 9), 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        for (int i = 0; i < DEPTH; i++) rd(4'(i));

        // Reset in the middle of normal traffic.
        wr(4'd1, 8'h77);
        step(1'b1, 1'b0, 1'b1, 4'd1, 8'h88, 1'b1, 4'd1);
        repeat (DEPTH) idle_step();
        rd(4'd1);

        // Random traffic with occasional clears.
        for (int i = 0; i < 200; i++) begin
            step(1'b0, ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        repeat (DEPTH + 1) idle_step();
        for (int i = 0; i < DEPTH; i++) rd(4'(i));
        idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_ram_clr
